cache_dm_param: RTL

Parametrised direct-mapped, write-through, no-write-allocate data cache between the CPU load/store port and a memory with a request/ready handshake. It is the next generation of the single-entry cache controller: configurable address/data width and line count, valid bits with full invalidation (flush), a busy flag, and saturating hit/miss counters. One word per line, word-addressed.

---
 rtl/cache_pkg.sv | 38 +++
 rtl/cache_line_array.sv | 52 +++++
 rtl/cache_dm_param.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and address helpers for the direct-mapped cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_RD   = 2'd1,
        MEM_WR   = 2'd2,
        FLUSHING = 2'd3
    } state_t;

    // Widest address the slice helpers accept; callers zero-extend into this.
    localparam int MAX_ADDR_W = 64;

    // Ceiling log2 for elaboration-time sizing of the index field.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Line index: the low idx_w bits of the word address.
    function automatic logic [MAX_ADDR_W-1:0] addr_index(input logic [MAX_ADDR_W-1:0] addr,
                                                         input int idx_w);
        logic [MAX_ADDR_W-1:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return addr & mask;
    endfunction

    // Tag: everything above the index field.
    function automatic logic [MAX_ADDR_W-1:0] addr_tag(input logic [MAX_ADDR_W-1:0] addr,
                                                       input int idx_w);
        return addr >> idx_w;
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage: combinational read, one write port, per-line valid clear.
module cache_line_array #(
    parameter int LINES  = 16,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 28,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_en,
    input  logic [IDX_W-1:0]  clr_idx
);

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    // Next valid vector: a write marks its line valid, a flush step clears one line.
    always_comb begin
        valid_d = valid_q;
        if (clr_en) valid_d[clr_idx] = 1'b0;
        if (wr_en)  valid_d[wr_idx]  = 1'b1;
    end

    // Valid bits drop asynchronously on reset so no stale line can ever hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    // Tag/data need no reset; they are qualified by valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/cache_dm_param.sv
// Direct-mapped write-through, no-write-allocate cache with flush and hit/miss counters.
module cache_dm_param
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] DOUT,
    output logic              RDY,
    output logic              BUSY,
    input  logic              FLUSH,
    output logic              MREQ,
    output logic              MWE,
    output logic [ADDR_W-1:0] MADDR,
    output logic [DATA_W-1:0] MDOUT,
    input  logic [DATA_W-1:0] MDIN,
    input  logic              MRDY,
    output logic [CNT_W-1:0]  HITS,
    output logic [CNT_W-1:0]  MISSES
);

    localparam int IDX_W = clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    function automatic logic [MAX_ADDR_W-1:0] widen(input logic [ADDR_W-1:0] a);
        logic [MAX_ADDR_W-1:0] w;
        w = '0;
        w[ADDR_W-1:0] = a;
        return w;
    endfunction

    state_t            state_q, state_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;
    logic              mreq_q, mreq_d;
    logic              mwe_q, mwe_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mdout_q, mdout_d;
    logic [CNT_W-1:0]  hits_q, hits_d;
    logic [CNT_W-1:0]  misses_q, misses_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;

    logic [IDX_W-1:0]  idx_in, idx_lat;
    logic [TAG_W-1:0]  tag_in, tag_lat;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              hit;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [TAG_W-1:0]  wr_tag;
    logic [DATA_W-1:0] wr_data;
    logic              clr_en;

    // Incoming request is looked up directly; MADDR doubles as the latched address for fills.
    assign idx_in  = IDX_W'(addr_index(widen(ADDR), IDX_W));
    assign tag_in  = TAG_W'(addr_tag(widen(ADDR), IDX_W));
    assign idx_lat = IDX_W'(addr_index(widen(maddr_q), IDX_W));
    assign tag_lat = TAG_W'(addr_tag(widen(maddr_q), IDX_W));
    assign hit     = rd_valid && (rd_tag == tag_in);

    cache_line_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W),
        .DATA_W(DATA_W)
    ) u_lines (
        .clk     (CLK),
        .rst     (RST),
        .rd_idx  (idx_in),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_tag  (wr_tag),
        .wr_data (wr_data),
        .clr_en  (clr_en),
        .clr_idx (cnt_q)
    );

    // Next-state, line-array write control and output register inputs.
    always_comb begin
        state_d  = state_q;
        dout_d   = dout_q;
        rdy_d    = 1'b0;
        mreq_d   = mreq_q;
        mwe_d    = mwe_q;
        maddr_d  = maddr_q;
        mdout_d  = mdout_q;
        hits_d   = hits_q;
        misses_d = misses_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        wr_idx   = idx_in;
        wr_tag   = tag_in;
        wr_data  = DIN;
        clr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (FLUSH) begin
                    state_d = FLUSHING;
                    cnt_d   = '0;
                end else if (REQ) begin
                    if (WE) begin
                        // Store-hit updates the line now; a store miss does not allocate.
                        state_d = MEM_WR;
                        mreq_d  = 1'b1;
                        mwe_d   = 1'b1;
                        maddr_d = ADDR;
                        mdout_d = DIN;
                        wr_en   = hit;
                    end else if (hit) begin
                        rdy_d  = 1'b1;
                        dout_d = rd_data;
                        if (hits_q != {CNT_W{1'b1}}) hits_d = hits_q + 1'b1;
                    end else begin
                        state_d = MEM_RD;
                        mreq_d  = 1'b1;
                        mwe_d   = 1'b0;
                        maddr_d = ADDR;
                        if (misses_q != {CNT_W{1'b1}}) misses_d = misses_q + 1'b1;
                    end
                end
            end
            MEM_RD: begin
                if (MRDY) begin
                    wr_en   = 1'b1;
                    wr_idx  = idx_lat;
                    wr_tag  = tag_lat;
                    wr_data = MDIN;
                    dout_d  = MDIN;
                    rdy_d   = 1'b1;
                    mreq_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            MEM_WR: begin
                if (MRDY) begin
                    rdy_d   = 1'b1;
                    mreq_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            FLUSHING: begin
                clr_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == {IDX_W{1'b1}}) begin
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Registered state and outputs; reset abandons any memory transaction at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            dout_q   <= '0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mdout_q  <= '0;
            hits_q   <= '0;
            misses_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            dout_q   <= dout_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
            mreq_q   <= mreq_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mdout_q  <= mdout_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
            cnt_q    <= cnt_d;
        end
    end

    assign DOUT   = dout_q;
    assign RDY    = rdy_q;
    assign BUSY   = busy_q;
    assign MREQ   = mreq_q;
    assign MWE    = mwe_q;
    assign MADDR  = maddr_q;
    assign MDOUT  = mdout_q;
    assign HITS   = hits_q;
    assign MISSES = misses_q;

endmodule
